// File: rtl/rotating_register_file.sv
// Multi-port register file with a rotating base pointer for modulo-scheduled loops.
// Logical addresses are offset by the base; reads are registered with optional write forwarding.
module rotating_register_file #(
    parameter int SIZE      = 32,
    parameter int LOG2REGS  = 2,
    parameter int NUM_WRITE = 2,
    parameter int NUM_READ  = 2,
    parameter int BYPASS    = 0
) (
    input  logic                          CGRA_Clock,
    input  logic                          CGRA_Reset,
    input  logic                          clear,
    input  logic                          rotate,
    input  logic [NUM_WRITE-1:0]          WE,
    input  logic [NUM_WRITE*LOG2REGS-1:0] address_in,
    input  logic [NUM_WRITE*SIZE-1:0]     in,
    input  logic [NUM_READ*LOG2REGS-1:0]  address_out,
    output logic [NUM_READ*SIZE-1:0]      out,
    output logic [LOG2REGS-1:0]           base
);

    localparam int N = 2 ** LOG2REGS;

    logic [SIZE-1:0]          regs_r      [N];
    logic [SIZE-1:0]          regs_next_s [N];
    logic [LOG2REGS-1:0]      wphys_s     [NUM_WRITE];
    logic [LOG2REGS-1:0]      rphys_s     [NUM_READ];
    logic [LOG2REGS-1:0]      base_r;
    logic [LOG2REGS-1:0]      base_next_s;
    logic [NUM_READ*SIZE-1:0] out_r;
    logic [NUM_READ*SIZE-1:0] rd_s;

    // Post-edge register image, physical indices and read data for this cycle
    always_comb begin
        regs_next_s = regs_r;
        rd_s        = {(NUM_READ*SIZE){1'b0}};
        // Ascending port order makes the highest-numbered port win a conflict
        for (int w = 0; w < NUM_WRITE; w++) begin
            wphys_s[w] = address_in[w*LOG2REGS +: LOG2REGS] + base_r;
            if (WE[w]) begin
                regs_next_s[wphys_s[w]] = in[w*SIZE +: SIZE];
            end else begin
                regs_next_s[wphys_s[w]] = regs_next_s[wphys_s[w]];
            end
        end
        // Forwarding is simply reading the post-write image instead of the current one
        for (int k = 0; k < NUM_READ; k++) begin
            rphys_s[k] = address_out[k*LOG2REGS +: LOG2REGS] + base_r;
            if (BYPASS != 0) begin
                rd_s[k*SIZE +: SIZE] = regs_next_s[rphys_s[k]];
            end else begin
                rd_s[k*SIZE +: SIZE] = regs_r[rphys_s[k]];
            end
        end
    end

    // Next rotation base, wrapping naturally at N
    always_comb begin
        if (rotate) begin
            base_next_s = base_r + LOG2REGS'(1);
        end else begin
            base_next_s = base_r;
        end
    end

    // State update: async reset, then clear overriding writes, rotate and reads
    always_ff @(posedge CGRA_Clock or posedge CGRA_Reset) begin
        if (CGRA_Reset) begin
            for (int i = 0; i < N; i++) begin
                regs_r[i] <= {SIZE{1'b0}};
            end
            base_r <= {LOG2REGS{1'b0}};
            out_r  <= {(NUM_READ*SIZE){1'b0}};
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                regs_r[i] <= {SIZE{1'b0}};
            end
            base_r <= {LOG2REGS{1'b0}};
            out_r  <= {(NUM_READ*SIZE){1'b0}};
        end else begin
            for (int i = 0; i < N; i++) begin
                regs_r[i] <= regs_next_s[i];
            end
            base_r <= base_next_s;
            out_r  <= rd_s;
        end
    end

    assign out  = out_r;
    assign base = base_r;

endmodule

// File: tb/tb_rotating_register_file.sv
// Directed plus random checks of rotating_register_file, run with and without write forwarding.
module tb_rotating_register_file;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        rotate;
    logic [1:0]  we;
    logic [3:0]  ain;
    logic [63:0] din;
    logic [3:0]  aout;
    logic [63:0] out_nb;
    logic [63:0] out_b;
    logic [1:0]  base_nb;
    logic [1:0]  base_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] o_nb;
        logic [63:0] o_b;
        logic [1:0]  b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_reg[4];
    logic [1:0]  m_base;

    rotating_register_file #(.SIZE(32), .LOG2REGS(2), .NUM_WRITE(2), .NUM_READ(2), .BYPASS(0)) dut_nb (
        .CGRA_Clock(clk), .CGRA_Reset(rst), .clear(clear), .rotate(rotate), .WE(we),
        .address_in(ain), .in(din), .address_out(aout), .out(out_nb), .base(base_nb)
    );

    rotating_register_file #(.SIZE(32), .LOG2REGS(2), .NUM_WRITE(2), .NUM_READ(2), .BYPASS(1)) dut_b (
        .CGRA_Clock(clk), .CGRA_Reset(rst), .clear(clear), .rotate(rotate), .WE(we),
        .address_in(ain), .in(din), .address_out(aout), .out(out_b), .base(base_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 32'h0;
        m_base = 2'd0;
    endtask

    // Drive one cycle, predict both DUTs, compare after the edge
    task automatic step(input logic c, input logic r, input logic [1:0] w,
                        input logic [1:0] a0, input logic [1:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] r0, input logic [1:0] r1);
        logic [31:0] nxt[4];
        logic [1:0]  p;
        exp_t        e;
        exp_t        got;
        clear = c; rotate = r; we = w;
        ain = {a1, a0}; din = {d1, d0}; aout = {r1, r0};
        p = r0 + m_base; e.o_nb[31:0]  = m_reg[p];
        p = r1 + m_base; e.o_nb[63:32] = m_reg[p];
        for (int i = 0; i < 4; i++) nxt[i] = m_reg[i];
        if (w[0]) begin p = a0 + m_base; nxt[p] = d0; end
        if (w[1]) begin p = a1 + m_base; nxt[p] = d1; end
        p = r0 + m_base; e.o_b[31:0]  = nxt[p];
        p = r1 + m_base; e.o_b[63:32] = nxt[p];
        if (r) m_base = m_base + 2'd1;
        if (c) begin
            for (int i = 0; i < 4; i++) nxt[i] = 32'h0;
            m_base = 2'd0;
            e.o_nb = 64'h0;
            e.o_b  = 64'h0;
        end
        for (int i = 0; i < 4; i++) m_reg[i] = nxt[i];
        e.b = m_base;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            got = sb.pop_front();
            chk("out_nobypass", out_nb, got.o_nb);
            chk("out_bypass", out_b, got.o_b);
            chk("base_nobypass", {62'd0, base_nb}, {62'd0, got.b});
            chk("base_bypass", {62'd0, base_b}, {62'd0, got.b});
        end
    endtask

    task automatic idle_inputs();
        clear = 1'b0; rotate = 1'b0; we = 2'b00; ain = 4'h0; din = 64'h0; aout = 4'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", out_nb | out_b, 64'h0);
        chk("reset_base", {62'd0, base_nb | base_b}, 64'h0);
        rst = 1'b0;

        // Scenario 1: fill with non-zero data, rotate, then reset mid-operation
        step(1'b0, 1'b0, 2'b11, 2'd0, 2'd1, 32'h1111_0000, 32'h2222_0001, 2'd0, 2'd1);
        step(1'b0, 1'b1, 2'b11, 2'd2, 2'd3, 32'h3333_0002, 32'h4444_0003, 2'd0, 2'd1);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd2, 2'd3);
        #2;
        we = 2'b11; rotate = 1'b1; din = 64'hFFFF_FFFF_FFFF_FFFF;
        rst = 1'b1;
        #1;
        chk("async_reset_out_nb", out_nb, 64'h0);
        chk("async_reset_out_b", out_b, 64'h0);
        chk("async_reset_base", {62'd0, base_nb | base_b}, 64'h0);
        @(posedge clk);
        #1;
        chk("held_reset_out", out_nb | out_b, 64'h0);
        chk("held_reset_base", {62'd0, base_nb | base_b}, 64'h0);
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd0, 2'd1);
        chk("post_reset_a01", out_nb, 64'h0);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd2, 2'd3);
        chk("post_reset_a23", out_nb, 64'h0);

        // Scenarios 2 and 3: same-cycle write and read of address 1
        step(1'b0, 1'b0, 2'b01, 2'd1, 2'd0, 32'hDEAD_BEEF, 32'h0, 2'd1, 2'd0);
        chk("s2_nobypass_cyc1", {32'h0, out_nb[31:0]}, 64'h0);
        chk("s3_bypass_cyc1", {32'h0, out_b[31:0]}, 64'h0000_0000_DEAD_BEEF);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd1, 2'd0);
        chk("s2_nobypass_cyc2", {32'h0, out_nb[31:0]}, 64'h0000_0000_DEAD_BEEF);

        // Scenario 4: both ports write address 2, port 1 wins
        step(1'b0, 1'b0, 2'b11, 2'd2, 2'd2, 32'h11, 32'h22, 2'd2, 2'd0);
        chk("s4_bypass_same_cycle", {32'h0, out_b[31:0]}, 64'h22);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd2, 2'd2);
        chk("s4_conflict_read", out_nb, 64'h0000_0022_0000_0022);

        // Scenario 5: rotation
        step(1'b0, 1'b0, 2'b01, 2'd3, 2'd0, 32'hA5, 32'h0, 2'd0, 2'd0);
        step(1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd3, 2'd0);
        chk("s5_rotate_old_base_read", {32'h0, out_nb[31:0]}, 64'hA5);
        chk("s5_base_after_one", {62'd0, base_nb}, 64'd1);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd2, 2'd0);
        chk("s5_logical2_after_rotate", {32'h0, out_nb[31:0]}, 64'hA5);
        step(1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd0, 2'd0);
        step(1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd0, 2'd0);
        step(1'b0, 1'b1, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd0, 2'd0);
        chk("s5_base_wrap", {62'd0, base_nb}, 64'd0);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd3, 2'd0);
        chk("s5_logical3_after_wrap", {32'h0, out_nb[31:0]}, 64'hA5);
        step(1'b0, 1'b1, 2'b01, 2'd1, 2'd0, 32'h77, 32'h0, 2'd0, 2'd0);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd0, 2'd2);
        chk("s5_write_uses_old_base", out_nb, 64'h0000_00A5_0000_0077);

        // Scenario 6: clear beats write, rotate and read
        step(1'b1, 1'b1, 2'b01, 2'd0, 2'd0, 32'h55, 32'h0, 2'd3, 2'd0);
        chk("s6_clear_out", out_nb | out_b, 64'h0);
        chk("s6_clear_base", {62'd0, base_nb | base_b}, 64'h0);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd0, 2'd1);
        chk("s6_read_a01", out_nb, 64'h0);
        step(1'b0, 1'b0, 2'b00, 2'd0, 2'd0, 32'h0, 32'h0, 2'd2, 2'd3);
        chk("s6_read_a23", out_nb, 64'h0);

        // Random traffic against the scoreboard model
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0), 2'($urandom),
                 2'($urandom), 2'($urandom), $urandom, $urandom, 2'($urandom), 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
